// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests for the current PC, buffers a
// returned word while decode is stalled, and squashes in-flight fetches on redirect.
module fetch_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    output logic [31:0] PCNext,
    output logic        PCWrite,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddr,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pcplus4;
    logic        r_if_id_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pcplus4;
    logic [31:0] r_drop_addr;

    logic [31:0] w_pc_plus4;
    logic        w_load_from_mem;
    logic        w_load_from_skid;
    logic        w_clear_valid;
    logic        w_load_skid;
    logic        w_latch_drop;

    assign w_pc_plus4 = PCResult + 32'd4;

    assign IF_ID_Instr   = r_if_id_instr;
    assign IF_ID_PCPlus4 = r_if_id_pcplus4;
    assign IF_ID_Valid   = r_if_id_valid;

    // NOTE: every output of this block gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_next     = r_state;
        PCWrite          = 1'b0;
        PCNext           = PCResult;
        IMemReq          = (r_state != S_HOLD);
        IMemAddr         = (r_state == S_DROP) ? r_drop_addr : PCResult;
        w_load_from_mem  = 1'b0;
        w_load_from_skid = 1'b0;
        w_clear_valid    = 1'b0;
        w_load_skid      = 1'b0;
        w_latch_drop     = 1'b0;

        if (Reset) begin
            // Any outstanding transaction is abandoned; acks are ignored.
            IMemReq  = 1'b0;
            IMemAddr = PCResult;
        end else if (Redirect) begin
            PCWrite       = 1'b1;
            PCNext        = RedirectAddr;
            w_clear_valid = 1'b1;
            if (r_state != S_HOLD && !IMemAck) begin
                // The in-flight request must still complete at its old address.
                w_state_next = S_DROP;
                w_latch_drop = (r_state == S_REQ);
            end else begin
                w_state_next = S_REQ;
            end
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (IMemAck) begin
                        if (!Stall) begin
                            PCWrite         = 1'b1;
                            PCNext          = w_pc_plus4;
                            w_load_from_mem = 1'b1;
                        end else begin
                            w_load_skid  = 1'b1;
                            w_state_next = S_HOLD;
                        end
                    end else if (!Stall) begin
                        w_clear_valid = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        PCWrite          = 1'b1;
                        PCNext           = r_skid_pcplus4;
                        w_load_from_skid = 1'b1;
                        w_state_next     = S_REQ;
                    end
                end
                S_DROP: begin
                    if (IMemAck) begin
                        w_state_next = S_REQ;
                    end
                    if (!Stall) begin
                        w_clear_valid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_REQ;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state         <= S_REQ;
            r_if_id_instr   <= 32'd0;
            r_if_id_pcplus4 <= 32'd0;
            r_if_id_valid   <= 1'b0;
            r_skid_instr    <= 32'd0;
            r_skid_pcplus4  <= 32'd0;
            r_drop_addr     <= 32'd0;
        end else begin
            r_state <= w_state_next;

            if (w_latch_drop) begin
                r_drop_addr <= PCResult;
            end

            if (w_load_skid) begin
                r_skid_instr   <= IMemRData;
                r_skid_pcplus4 <= w_pc_plus4;
            end

            if (w_load_from_mem) begin
                r_if_id_instr   <= IMemRData;
                r_if_id_pcplus4 <= w_pc_plus4;
                r_if_id_valid   <= 1'b1;
            end else if (w_load_from_skid) begin
                r_if_id_instr   <= r_skid_instr;
                r_if_id_pcplus4 <= r_skid_pcplus4;
                r_if_id_valid   <= 1'b1;
            end else if (w_clear_valid) begin
                r_if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// traffic, all compared against a flag-based behavioural model of the fetch stage.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCResult;
    logic [31:0] PCNext;
    logic        PCWrite;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRData;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectAddr;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;

    always #5 Clk = ~Clk;

    fetch_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCResult     (PCResult),
        .PCNext       (PCNext),
        .PCWrite      (PCWrite),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemRData    (IMemRData),
        .Stall        (Stall),
        .Redirect     (Redirect),
        .RedirectAddr (RedirectAddr),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid  (IF_ID_Valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model: "have a buffered word" and "outstanding result is to be thrown away".
    logic        m_buf_valid;
    logic [31:0] m_buf_instr;
    logic [31:0] m_buf_pc4;
    logic        m_discard;
    logic [31:0] m_drop_addr;
    logic [31:0] m_ifid_instr;
    logic [31:0] m_ifid_pc4;
    logic        m_ifid_valid;

    logic        obs_pcw;
    logic [31:0] obs_pcnext;
    logic        obs_req;
    logic [31:0] obs_addr;

    task automatic cycle(input logic rst, input logic stall, input logic redir, input logic ack,
                         input logic [31:0] data, input logic [31:0] raddr);
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_pcw;
        logic [31:0] e_pcnext;
        logic        n_buf_valid;
        logic [31:0] n_buf_instr;
        logic [31:0] n_buf_pc4;
        logic        n_discard;
        logic [31:0] n_drop_addr;
        logic [31:0] n_ifid_instr;
        logic [31:0] n_ifid_pc4;
        logic        n_ifid_valid;
        logic [31:0] pc4;

        @(negedge Clk);
        Reset        = rst;
        Stall        = stall;
        Redirect     = redir;
        IMemAck      = ack;
        IMemRData    = data;
        RedirectAddr = raddr;
        #1;

        pc4          = PCResult + 32'd4;
        e_pcw        = 1'b0;
        e_pcnext     = PCResult;
        n_buf_valid  = m_buf_valid;
        n_buf_instr  = m_buf_instr;
        n_buf_pc4    = m_buf_pc4;
        n_discard    = m_discard;
        n_drop_addr  = m_drop_addr;
        n_ifid_instr = m_ifid_instr;
        n_ifid_pc4   = m_ifid_pc4;
        n_ifid_valid = m_ifid_valid;

        if (rst) begin
            e_req        = 1'b0;
            e_addr       = PCResult;
            n_buf_valid  = 1'b0;
            n_buf_instr  = 32'd0;
            n_buf_pc4    = 32'd0;
            n_discard    = 1'b0;
            n_drop_addr  = 32'd0;
            n_ifid_instr = 32'd0;
            n_ifid_pc4   = 32'd0;
            n_ifid_valid = 1'b0;
        end else begin
            e_req  = !m_buf_valid;
            e_addr = m_discard ? m_drop_addr : PCResult;
            if (redir) begin
                e_pcw        = 1'b1;
                e_pcnext     = raddr;
                n_ifid_valid = 1'b0;
                n_buf_valid  = 1'b0;
                if (!m_buf_valid && !ack) begin
                    if (!m_discard) n_drop_addr = PCResult;
                    n_discard = 1'b1;
                end else begin
                    n_discard = 1'b0;
                end
            end else if (m_buf_valid) begin
                if (!stall) begin
                    e_pcw        = 1'b1;
                    e_pcnext     = m_buf_pc4;
                    n_ifid_instr = m_buf_instr;
                    n_ifid_pc4   = m_buf_pc4;
                    n_ifid_valid = 1'b1;
                    n_buf_valid  = 1'b0;
                end
            end else if (m_discard) begin
                if (ack) n_discard = 1'b0;
                if (!stall) n_ifid_valid = 1'b0;
            end else if (ack) begin
                if (!stall) begin
                    e_pcw        = 1'b1;
                    e_pcnext     = pc4;
                    n_ifid_instr = data;
                    n_ifid_pc4   = pc4;
                    n_ifid_valid = 1'b1;
                end else begin
                    n_buf_valid = 1'b1;
                    n_buf_instr = data;
                    n_buf_pc4   = pc4;
                end
            end else if (!stall) begin
                n_ifid_valid = 1'b0;
            end
        end

        obs_pcw    = PCWrite;
        obs_pcnext = PCNext;
        obs_req    = IMemReq;
        obs_addr   = IMemAddr;
        check("imem_req", IMemReq, e_req);
        if (e_req) check("imem_addr", IMemAddr, e_addr);
        check("pc_write", PCWrite, e_pcw);
        check("pc_next", PCNext, e_pcnext);

        @(posedge Clk);
        #1;
        m_buf_valid  = n_buf_valid;
        m_buf_instr  = n_buf_instr;
        m_buf_pc4    = n_buf_pc4;
        m_discard    = n_discard;
        m_drop_addr  = n_drop_addr;
        m_ifid_instr = n_ifid_instr;
        m_ifid_pc4   = n_ifid_pc4;
        m_ifid_valid = n_ifid_valid;
        if (e_pcw) PCResult = e_pcnext;

        check("ifid_valid", IF_ID_Valid, m_ifid_valid);
        check("ifid_instr", IF_ID_Instr, m_ifid_instr);
        check("ifid_pc4", IF_ID_PCPlus4, m_ifid_pc4);
    endtask

    task automatic idle(input logic stall, input logic ack, input logic [31:0] data);
        cycle(1'b0, stall, 1'b0, ack, data, 32'd0);
    endtask

    task automatic do_reset(input logic [31:0] pc);
        PCResult = pc;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'd0);
        check("rst_valid", IF_ID_Valid, 32'd0);
        check("rst_instr", IF_ID_Instr, 32'd0);
    endtask

    initial begin
        logic        rst;
        logic        stall;
        logic        redir;
        logic        ack;
        logic [31:0] raddr;

        Reset        = 1'b1;
        PCResult     = 32'd0;
        IMemAck      = 1'b0;
        IMemRData    = 32'd0;
        Stall        = 1'b0;
        Redirect     = 1'b0;
        RedirectAddr = 32'd0;
        m_buf_valid  = 1'b0;
        m_buf_instr  = 32'd0;
        m_buf_pc4    = 32'd0;
        m_discard    = 1'b0;
        m_drop_addr  = 32'd0;
        m_ifid_instr = 32'd0;
        m_ifid_pc4   = 32'd0;
        m_ifid_valid = 1'b0;

        // Zero-based fetch with a two-cycle memory latency.
        do_reset(32'd0);
        idle(1'b0, 1'b0, 32'd0);
        check("first_req", obs_req, 32'd1);
        check("first_addr", obs_addr, 32'd0);
        idle(1'b0, 1'b0, 32'd0);
        idle(1'b0, 1'b1, 32'h20080005);
        check("d1_pcw", obs_pcw, 32'd1);
        check("d1_pcnext", obs_pcnext, 32'd4);
        check("d1_instr", IF_ID_Instr, 32'h20080005);
        check("d1_pc4", IF_ID_PCPlus4, 32'd4);
        check("d1_valid", IF_ID_Valid, 32'd1);

        // Ack under stall parks the word; release delivers it exactly once.
        do_reset(32'h0000000C);
        idle(1'b0, 1'b1, 32'h11111111);
        idle(1'b1, 1'b1, 32'h22222222);
        check("hold_pcw", obs_pcw, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b1, 32'h33333333);
            check("hold_req", obs_req, 32'd0);
            check("hold_pcw2", obs_pcw, 32'd0);
            check("hold_instr", IF_ID_Instr, 32'h11111111);
        end
        idle(1'b0, 1'b0, 32'd0);
        check("rel_pcw", obs_pcw, 32'd1);
        check("rel_pcnext", obs_pcnext, 32'h14);
        check("rel_instr", IF_ID_Instr, 32'h22222222);
        check("rel_pc4", IF_ID_PCPlus4, 32'h14);

        // Redirect while a request is outstanding.
        do_reset(32'd8);
        idle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h100);
        check("rd_pcw", obs_pcw, 32'd1);
        check("rd_pcnext", obs_pcnext, 32'h100);
        check("rd_valid", IF_ID_Valid, 32'd0);
        idle(1'b0, 1'b0, 32'd0);
        check("drop_addr", obs_addr, 32'd8);
        idle(1'b0, 1'b1, 32'h44444444);
        check("drop_addr2", obs_addr, 32'd8);
        check("drop_pcw", obs_pcw, 32'd0);
        check("drop_valid", IF_ID_Valid, 32'd0);
        idle(1'b0, 1'b0, 32'd0);
        check("after_drop_addr", obs_addr, 32'h100);

        // Redirect together with ack and stall.
        do_reset(32'h20);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h55555555, 32'h200);
        check("rsa_pcnext", obs_pcnext, 32'h200);
        check("rsa_valid", IF_ID_Valid, 32'd0);
        idle(1'b0, 1'b0, 32'd0);
        check("rsa_req", obs_req, 32'd1);
        check("rsa_addr", obs_addr, 32'h200);

        // PC wrap-around.
        do_reset(32'hFFFFFFFC);
        idle(1'b0, 1'b1, 32'h66666666);
        check("wrap_pcnext", obs_pcnext, 32'd0);
        check("wrap_pc4", IF_ID_PCPlus4, 32'd0);

        // Reset lands while dropping, with a late ack during reset.
        do_reset(32'h40);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h80);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h77777777, 32'd0);
        check("rdrop_pcw", obs_pcw, 32'd0);
        check("rdrop_instr", IF_ID_Instr, 32'd0);
        check("rdrop_valid", IF_ID_Valid, 32'd0);
        idle(1'b0, 1'b0, 32'd0);
        check("rdrop_req", obs_req, 32'd1);
        check("rdrop_addr", obs_addr, 32'h80);

        // Randomized traffic, including spurious acks while holding.
        do_reset(32'h1000);
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 2) == 0);
            redir = ($urandom_range(0, 7) == 0);
            if (!m_buf_valid) ack = ($urandom_range(0, 2) == 0);
            else              ack = ($urandom_range(0, 7) == 0);
            raddr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom() & 32'hFFFFFFFC);
            cycle(rst, stall, redir, ack, $urandom(), raddr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
